// File: rtl/bram_stream_reader.sv
// Streams a contiguous BRAM address range out as valid/ready words; first word valid 3 cycles after start.
// Reads stall whenever FIFO slots plus the in-flight read would exceed FIFO_DEPTH, so back-pressure never drops data.

module bram_stream_reader_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_vld_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_rdy_i,
  output logic                         pop_vld_o,
  output logic [WIDTH-1:0]             pop_dat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  always_comb begin
    pop      = pop_rdy_i && (count_q != '0);
    push     = push_vld_i && ((count_q != FULL_C) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_vld_o = (count_q != '0);
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

module bram_stream_reader #(
  parameter int DATA       = 72,
  parameter int ADDR       = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [ADDR-1:0] base_addr_i,
  input  logic [ADDR:0]   count_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [ADDR-1:0] mem_addr_o,
  input  logic [DATA-1:0] mem_rd_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DATA-1:0] out_data_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [ADDR:0]    REM_ONE = (ADDR + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [ADDR-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR:0]    remaining_q, remaining_d;
  logic             inflight_q, inflight_d;
  logic             done_q, done_d;
  logic             issue;
  logic             credit_ok;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;

  // The read in flight already owns a slot, so it counts against the FIFO space.
  assign credit_ok = inflight_q ? (fifo_count < (DEPTH_C - ONE_C)) : (fifo_count < DEPTH_C);
  assign pop       = out_valid_o && out_ready_i;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (count_i != '0) begin
            state_d     = S_RUN;
            addr_d      = base_addr_i;
            remaining_d = count_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        issue = (remaining_q != '0) && credit_ok;
        if (issue) begin
          mem_addr_d  = addr_q;
          addr_d      = addr_q + ADDR'(1);
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finish on the edge that pops the last word so done lands right after the final handshake.
        if (!inflight_q && ((fifo_count == '0) || ((fifo_count == ONE_C) && pop))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    inflight_d = issue;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
    end
  end

  bram_stream_reader_fifo #(
    .WIDTH (DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_vld_i (inflight_q),
    .push_dat_i (mem_rd_data_i),
    .pop_rdy_i  (out_ready_i),
    .pop_vld_o  (out_valid_o),
    .pop_dat_o  (out_data_o),
    .count_o    (fifo_count)
  );

  assign mem_addr_o = mem_addr_d;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;

endmodule
